// File: rtl/gnt_mux_skid.sv
// gnt_mux_skid: captures the payload of the granted requestor into a
// 2-entry first-in first-out skid buffer and presents the head entry downstream.
// Optional build macro: GNT_MUX_ONEHOT_CHECK_EN enables the sticky err flag
// raised when more than one grant bit is set while the buffer can accept a transfer.
module gnt_mux_skid #(
  parameter int NUM_REQ = 10,
  parameter int DATA_W  = 32,
  localparam int SRC_W  = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        gnt,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      gnt_ready,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [SRC_W-1:0]          out_src,
  input  logic                      out_ready,
  output logic                      err
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]   data0_q, data0_d;
  logic [DATA_W-1:0]   data1_q, data1_d;
  logic [SRC_W-1:0]    src0_q, src0_d;
  logic [SRC_W-1:0]    src1_q, src1_d;

  logic                push_s;
  logic                pop_s;
  logic [SRC_W-1:0]    cap_src_s;
  logic [DATA_W-1:0]   cap_data_s;
  logic [NUM_REQ-1:0]  gnt_low_s;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [SRC_W-1:0] lowest_idx(input logic [NUM_REQ-1:0] v);
    logic [SRC_W-1:0] idx;
    idx = {SRC_W{1'b0}};
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = SRC_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Readiness comes from the state register only; reset holds it low.
  always_comb begin
    gnt_ready = 1'b0;
    if (rst) begin
      gnt_ready = 1'b0;
    end else begin
      gnt_ready = (state_q != S_FULL);
    end
  end

  // Grant decode: isolate the lowest grant bit and select its payload.
  always_comb begin
    gnt_low_s  = gnt & (~gnt + NUM_REQ'(1));
    cap_src_s  = lowest_idx(gnt);
    cap_data_s = req_data[cap_src_s * DATA_W +: DATA_W];
    push_s     = (|gnt) && gnt_ready;
    pop_s      = out_valid && out_ready;
    req_ack    = {NUM_REQ{1'b0}};
    if (push_s) begin
      req_ack = gnt_low_s;
    end else begin
      req_ack = {NUM_REQ{1'b0}};
    end
  end

  // Head entry presentation from the storage registers.
  always_comb begin
    out_valid = (state_q != S_EMPTY);
    out_data  = data0_q;
    out_src   = src0_q;
    if (rd_ptr_q) begin
      out_data = data1_q;
      out_src  = src1_q;
    end else begin
      out_data = data0_q;
      out_src  = src0_q;
    end
  end

  // Next-state logic for occupancy, pointers and entry storage.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    data0_d  = data0_q;
    data1_d  = data1_q;
    src0_d   = src0_q;
    src1_d   = src1_q;

    if (push_s) begin
      if (wr_ptr_q == 1'b0) begin
        data0_d = cap_data_s;
        src0_d  = cap_src_s;
      end else begin
        data1_d = cap_data_s;
        src1_d  = cap_src_s;
      end
      wr_ptr_d = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case (state_q)
      S_EMPTY: begin
        if (push_s) begin
          state_d = S_ONE;
        end else begin
          state_d = S_EMPTY;
        end
      end
      S_ONE: begin
        if (push_s && !pop_s) begin
          state_d = S_FULL;
        end else if (pop_s && !push_s) begin
          state_d = S_EMPTY;
        end else begin
          state_d = S_ONE;
        end
      end
      S_FULL: begin
        if (pop_s) begin
          state_d = S_ONE;
        end else begin
          state_d = S_FULL;
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
  end

  // State and storage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      data0_q  <= {DATA_W{1'b0}};
      data1_q  <= {DATA_W{1'b0}};
      src0_q   <= {SRC_W{1'b0}};
      src1_q   <= {SRC_W{1'b0}};
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      src0_q   <= src0_d;
      src1_q   <= src1_d;
    end
  end

`ifdef GNT_MUX_ONEHOT_CHECK_EN
  logic err_q, err_d;
  logic multi_s;

  // Sticky flag: more than one grant bit while a transfer could be accepted.
  always_comb begin
    multi_s = |(gnt & (gnt - NUM_REQ'(1)));
    err_d   = err_q;
    if (multi_s && gnt_ready) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gnt_mux_skid.sv
// Directed self-checking bench for gnt_mux_skid (default parameters).
module tb_gnt_mux_skid;

  localparam int NUM_REQ = 10;
  localparam int DATA_W  = 32;
  localparam int SRC_W   = $clog2(NUM_REQ);

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      gnt_ready;
  logic [NUM_REQ-1:0]        req_ack;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic [SRC_W-1:0]          out_src;
  logic                      out_ready;
  logic                      err;

  int n_cmp;
  int n_bad;
  logic exp_err_multi;

  gnt_mux_skid #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .gnt(gnt), .req_data(req_data),
    .gnt_ready(gnt_ready), .req_ack(req_ack), .out_valid(out_valid),
    .out_data(out_data), .out_src(out_src), .out_ready(out_ready), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at negedge; advance across one rising edge back to the next negedge.
  task automatic adv();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_data();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_data[i*DATA_W +: DATA_W] = 32'hA5A5_0000 | 32'(i);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; gnt = 10'h004; out_ready = 1'b1;
    adv();
    #1;
    n_cmp++; if (gnt_ready !== 1'b0) begin n_bad++; $display("FAIL rst_gnt_ready got %b want 0", gnt_ready); end
    n_cmp++; if (req_ack !== 10'h000) begin n_bad++; $display("FAIL rst_req_ack got %h want 000", req_ack); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL rst_out_data got %h want 0", out_data); end
    n_cmp++; if (out_src !== 4'd0) begin n_bad++; $display("FAIL rst_out_src got %0d want 0", out_src); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b want 0", err); end
    adv();
  endtask

  task automatic test_single();
    rst = 1'b0; gnt = 10'h004; out_ready = 1'b1;
    #1;
    n_cmp++; if (gnt_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready got %b want 1", gnt_ready); end
    n_cmp++; if (req_ack !== 10'h004) begin n_bad++; $display("FAIL single_ack got %h want 004", req_ack); end
    adv();
    gnt = 10'h000;
    #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 32'hA5A5_0002) begin n_bad++; $display("FAIL single_data got %h want a5a50002", out_data); end
    n_cmp++; if (out_src !== 4'd2) begin n_bad++; $display("FAIL single_src got %0d want 2", out_src); end
    adv();
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_drain got %b want 0", out_valid); end
  endtask

  task automatic test_fill();
    out_ready = 1'b0; gnt = 10'h001;
    #1;
    n_cmp++; if (req_ack !== 10'h001) begin n_bad++; $display("FAIL fill_ack0 got %h want 001", req_ack); end
    adv();
    gnt = 10'h002;
    #1;
    n_cmp++; if (req_ack !== 10'h002) begin n_bad++; $display("FAIL fill_ack1 got %h want 002", req_ack); end
    n_cmp++; if (out_src !== 4'd0) begin n_bad++; $display("FAIL fill_head0 got %0d want 0", out_src); end
    adv();
    gnt = 10'h008;
    #1;
    n_cmp++; if (gnt_ready !== 1'b0) begin n_bad++; $display("FAIL fill_full_ready got %b want 0", gnt_ready); end
    n_cmp++; if (req_ack !== 10'h000) begin n_bad++; $display("FAIL fill_ack2 got %h want 000", req_ack); end
    adv();
    gnt = 10'h000;
    #1;
    n_cmp++; if (out_src !== 4'd0 || out_data !== 32'hA5A5_0000) begin n_bad++; $display("FAIL fill_hold got %0d/%h want 0/a5a50000", out_src, out_data); end
    out_ready = 1'b1;
    adv();
    #1;
    n_cmp++; if (out_valid !== 1'b1 || out_src !== 4'd1) begin n_bad++; $display("FAIL fill_second got %b/%0d want 1/1", out_valid, out_src); end
    n_cmp++; if (gnt_ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready_back got %b want 1", gnt_ready); end
    adv();
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL fill_empty got %b want 0", out_valid); end
  endtask

  task automatic test_full_pop();
    out_ready = 1'b0; gnt = 10'h008;
    adv();
    gnt = 10'h010 >> 0;
    gnt = 10'h004;
    adv();
    out_ready = 1'b1; gnt = 10'h010;
    #1;
    n_cmp++; if (req_ack !== 10'h000) begin n_bad++; $display("FAIL fullpop_ack got %h want 000", req_ack); end
    n_cmp++; if (out_src !== 4'd3) begin n_bad++; $display("FAIL fullpop_head got %0d want 3", out_src); end
    adv();
    gnt = 10'h000;
    #1;
    n_cmp++; if (gnt_ready !== 1'b1) begin n_bad++; $display("FAIL fullpop_ready got %b want 1", gnt_ready); end
    n_cmp++; if (out_valid !== 1'b1 || out_src !== 4'd2) begin n_bad++; $display("FAIL fullpop_next got %b/%0d want 1/2", out_valid, out_src); end
    adv();
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL fullpop_nopush got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0; gnt = 10'h001;
    adv();
    out_ready = 1'b1; gnt = 10'h200;
    for (int k = 0; k < 4; k++) begin
      req_data[9*DATA_W +: DATA_W] = 32'h9000_0000 + 32'(k);
      #1;
      n_cmp++; if (req_ack !== 10'h200) begin n_bad++; $display("FAIL b2b_ack[%0d] got %h want 200", k, req_ack); end
      adv();
      n_cmp++; if (out_valid !== 1'b1 || out_src !== 4'd9 || gnt_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_state[%0d] got v%b s%0d r%b want v1 s9 r1", k, out_valid, out_src, gnt_ready); end
      n_cmp++; if (out_data !== (32'h9000_0000 + 32'(k))) begin n_bad++; $display("FAIL b2b_data[%0d] got %h want %h", k, out_data, 32'h9000_0000 + 32'(k)); end
    end
    gnt = 10'h000;
    adv();
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_empty got %b want 0", out_valid); end
    load_data();
  endtask

  task automatic test_multi_grant();
    out_ready = 1'b0; gnt = 10'h006;
    #1;
    n_cmp++; if (req_ack !== 10'h002) begin n_bad++; $display("FAIL multi_ack got %h want 002", req_ack); end
    adv();
    gnt = 10'h000;
    #1;
    n_cmp++; if (out_src !== 4'd1 || out_data !== 32'hA5A5_0001) begin n_bad++; $display("FAIL multi_cap got %0d/%h want 1/a5a50001", out_src, out_data); end
    n_cmp++; if (err !== exp_err_multi) begin n_bad++; $display("FAIL multi_err got %b want %b", err, exp_err_multi); end
    out_ready = 1'b1;
    adv();
    adv();
    #1;
    n_cmp++; if (err !== exp_err_multi) begin n_bad++; $display("FAIL multi_err_hold got %b want %b", err, exp_err_multi); end
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0; gnt = 10'h001;
    adv();
    gnt = 10'h002;
    adv();
    gnt = 10'h000; rst = 1'b1;
    #1;
    n_cmp++; if (gnt_ready !== 1'b0) begin n_bad++; $display("FAIL rstfull_ready_in_rst got %b want 0", gnt_ready); end
    adv();
    rst = 1'b0; gnt = 10'h020;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || gnt_ready !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL rstfull_post got v%b r%b e%b want v0 r1 e0", out_valid, gnt_ready, err); end
    n_cmp++; if (out_data !== 32'h0 || out_src !== 4'd0) begin n_bad++; $display("FAIL rstfull_zero got %h/%0d want 0/0", out_data, out_src); end
    n_cmp++; if (req_ack !== 10'h020) begin n_bad++; $display("FAIL rstfull_first_push got %h want 020", req_ack); end
    adv();
    gnt = 10'h000; out_ready = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b1 || out_src !== 4'd5) begin n_bad++; $display("FAIL rstfull_new got %b/%0d want 1/5", out_valid, out_src); end
    adv();
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstfull_no_stale got %b want 0", out_valid); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
`ifdef GNT_MUX_ONEHOT_CHECK_EN
    exp_err_multi = 1'b1;
`else
    exp_err_multi = 1'b0;
`endif
    rst = 1'b1; gnt = 10'h000; out_ready = 1'b0;
    req_data = '0;
    load_data();
    @(negedge clk);
    test_reset();
    test_single();
    test_fill();
    test_full_pop();
    test_back_to_back();
    test_multi_grant();
    test_reset_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gnt_mux_skid.md
GNT_MUX_SKID -- requirements
Module: gnt_mux_skid

Interface
REQ-001: Parameter NUM_REQ, default 10, number of requestors; legal range 2..64.
REQ-002: Parameter DATA_W, default 32, payload width per requestor.
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: rst  input  1  synchronous, active-high reset.
REQ-005: gnt  input  NUM_REQ  one-hot grant from the upstream round-robin arbiter; all-zero means no grant.
REQ-006: req_data  input  NUM_REQ*DATA_W  flattened payloads; requestor i occupies bits [i*DATA_W +: DATA_W].
REQ-007: gnt_ready  output  1  buffer can accept a granted transfer this cycle.
REQ-008: req_ack  output  NUM_REQ  one-hot pulse to the requestor whose payload was captured this cycle.
REQ-009: out_valid  output  1  head entry valid.
REQ-010: out_data  output  DATA_W  head entry payload.
REQ-011: out_src  output  $clog2(NUM_REQ)  head entry source index.
REQ-012: out_ready  input  1  downstream consumer accepts head entry.
REQ-013: err  output  1  sticky grant-violation flag (see Configuration).

Function
REQ-014: Push condition: (|gnt) && gnt_ready; pop condition: out_valid && out_ready.
REQ-015: Storage: 2-entry FIFO of {src, data}; states EMPTY (0 entries), ONE (1), FULL (2).
REQ-016: Transitions: EMPTY->ONE on push; ONE->FULL on push without pop; ONE->EMPTY on pop without push; ONE->ONE on push and pop together; FULL->ONE on pop.
REQ-017: gnt_ready SHALL be 1 in EMPTY and ONE, 0 in FULL; decoded from state register only, no combinational path from out_ready or gnt.
REQ-018: In FULL, gnt is ignored: no capture, req_ack all-zero, even if out_ready=1 that cycle.
REQ-019: On push, captured src = index of lowest set bit of gnt; captured data = slice of that index.
REQ-020: req_ack = gnt masked to its lowest set bit when push, else all-zero; combinational, same cycle as push.
REQ-021: Latency: payload pushed in cycle N SHALL appear on out_valid/out_data/out_src in cycle N+1 when the FIFO was empty, or when it was ONE and pop occurred in N.
REQ-022: Ordering strictly first-in first-out; out_data/out_src SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023: out_valid = 1 in ONE and FULL, 0 in EMPTY; out_data/out_src are don't-care when out_valid=0 but SHALL not be X after reset.
REQ-024: Read/write pointers are 1 bit each and wrap 1->0.

Reset
REQ-025: rst=1 at a rising edge SHALL force state EMPTY, both pointers 0, out_valid=0, out_data=0, out_src=0, err=0.
REQ-026: Reset mid-operation SHALL discard all buffered entries; no req_ack while rst=1 (gnt_ready=0 during rst).
REQ-027: First push possible in the cycle after rst deasserts.

Configuration
REQ-028: Macro GNT_MUX_ONEHOT_CHECK_EN defined: err SHALL set one cycle after any cycle in which gnt has more than one bit set and gnt_ready=1, and SHALL remain 1 until rst.
REQ-029: Macro not defined: err SHALL be tied 0; port still present; datapath behaviour (REQ-019) identical in both builds.

Verification
REQ-030: Reset, then gnt=0x004, req_data slice2=0xA5A5_0002, out_ready=1 -> req_ack=0x004 same cycle; next cycle out_valid=1, out_data=0xA5A5_0002, out_src=2.
REQ-031: out_ready=0, grants 0x001, 0x002, 0x008 on three consecutive cycles -> first two acked, state FULL, gnt_ready=0, third req_ack=0; then out_ready=1 -> out_src 0, 1 in order.
REQ-032: FULL with out_ready=1 and gnt=0x010 same cycle -> pop occurs, no push, req_ack=0; gnt_ready=1 next cycle.
REQ-033: ONE with simultaneous push (gnt=0x200) and pop -> state stays ONE, next out_src=9, pointers wrap correctly over 4 such cycles.
REQ-034: gnt=0x006 with macro defined -> captured src=1, req_ack=0x002, err=1 next cycle and held until rst; without macro err stays 0.
REQ-035: rst asserted while FULL -> next cycle out_valid=0, gnt_ready=1, err=0; previously buffered data never emitted.
